bram_stream_player: RTL and testbench
=====================================

Name: bram_stream_player

Overview:
- Parametrised successor to the single-channel BRAM pattern streamer in the fast-command/link test path.
- Plays a programmable address window of a pattern BRAM onto an AXI stream. Supports free-run, orbit-synchronous (arbitrary period) and counted one-shot modes.
- Tolerates BRAM read latency and downstream backpressure through a credit-controlled prefetch FIFO.
- Register decode and clock crossing stay in the wrapper; this block takes decoded cfg_* ports in the clk domain.

Parameters:
- DATA_WIDTH, 32, stream and BRAM word width (multiple of 8).
- MEM_DEPTH, 2048, BRAM depth in words (power of two); ADDR_W = clog2(MEM_DEPTH).
- READ_LATENCY, 1, BRAM clock-to-data latency in cycles (1 or 2).
- PERIOD_W, 8, width of the orbit period field.
- REPEAT_W, 16, width of the one-shot repeat counter.

Ports:
- clk  in  1  IP clock; also drives bram_clk.
- aresetn  in  1  asynchronous active-low reset.
- cfg_enable  in  1  playback enable.
- cfg_mode  in  2  0 free-run, 1 orbit-sync, 2 one-shot, 3 reserved (behaves as 0).
- cfg_start_addr  in  ADDR_W  first word of the window.
- cfg_length  in  ADDR_W+1  window length in words; 0 means MEM_DEPTH.
- cfg_period_orbits  in  PERIOD_W  pattern period in orbits for mode 1; 0 means 1.
- cfg_repeat  in  REPEAT_W  window passes in mode 2; 0 means 1.
- cfg_force_sync  in  1  single-cycle restart strobe.
- fc_orbitSync  in  1  orbit-sync fast command, one-cycle pulse.
- bram_clk  out  1  equals clk.
- bram_rst  out  1  equals !aresetn.
- bram_en  out  1  read enable.
- bram_addr  out  32  byte address = word address × (DATA_WIDTH/8), zero-extended.
- bram_dout  in  DATA_WIDTH  read data.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on the last word of each window pass.
- m_axis_tuser  out  1  high on the first word after each restart.
- sts_running  out  1  playback active.
- sts_done  out  1  mode-2 playback complete.
- sts_pass_count  out  16  completed window passes since the last restart; wraps.

Behaviour:
- Reset values: tvalid, tlast, tuser, bram_en, sts_* all 0; bram_addr 0; orbit counter 0; FIFO empty.
- Restart event: the first of the following, once per cycle:
  - cfg_force_sync;
  - rising edge of cfg_enable;
  - in mode 1, fc_orbitSync while orbit_cnt == 0.
- On a restart:
  - latch all cfg_* values; cfg changes take effect only at the next restart;
  - read pointer = start, pass count = 0, sts_done = 0;
  - discard in-flight reads via an epoch bit and empty the FIFO.
  - Restart may withdraw tvalid or change tdata mid-transfer. This deliberately departs from AXIS; consumers are always-ready serializers.
- Orbit counter:
  - increments on every fc_orbitSync regardless of handshake;
  - wraps to 0 after period−1;
  - cfg_force_sync clears it to 0, and an fc_orbitSync in the same cycle is ignored.
- Read issue:
  - bram_en = 1 and bram_addr = read pointer when running and (outstanding reads + FIFO occupancy) < FIFO_DEPTH, where FIFO_DEPTH = READ_LATENCY + 2;
  - bram_addr and bram_en are registered outputs.
- Read pointer advance: word address = (start + offset) mod MEM_DEPTH. offset counts 0..length−1, then wraps to 0.
- Data capture:
  - capture bram_dout READ_LATENCY cycles after issue if the epoch matches;
  - push into the FIFO with tlast = (offset == length−1) and tuser = first read after restart.
- Output:
  - tvalid = FIFO not empty; pop on tvalid && tready;
  - tdata/tlast/tuser stay stable while tvalid && !tready.
- Latency: first post-restart word has tvalid = 1 exactly READ_LATENCY + 2 cycles after the edge that samples the restart.
- Throughput: 1 word/cycle sustained when tready is held high.
- Mode 2 (one-shot):
  - after issuing cfg_repeat full passes, stop issuing reads and drain the FIFO;
  - sts_done = 1 the cycle after the final tlast handshake, held until the next restart.
- sts_running = enabled && !sts_done. sts_pass_count increments on each tlast handshake.
- cfg_enable low: stop issuing reads on the next cycle, flush the FIFO, tvalid = 0 the cycle after.
- Asynchronous reset mid-stream: all state returns to reset values immediately. Playback resumes only after a restart event.

Test Plan:
- Mode 0, start=10, length=4, READ_LATENCY=1, tready=1, BRAM[i]=i → tdata 10,11,12,13,10,…; tlast on every 13; tuser on the first 10 only; first tvalid 3 cycles after enable rises.
- Same setup with tready toggling 1-0-0-1 randomly → no word lost or duplicated; data stable while stalled; FIFO never overflows; repeat with READ_LATENCY=2.
- Mode 1, period=3, length=8, orbitSync every 20 cycles → restart (tuser=1, tdata=BRAM[start]) on every third orbitSync; force_sync coincident with orbitSync gives a single restart and orbit_cnt=0.
- Mode 2, repeat=2, length=3 → exactly 6 beats, 2 tlasts, then tvalid=0; sts_done=1 the cycle after the last handshake; sts_pass_count=2.
- Wrap: start=2046, length=4, MEM_DEPTH=2048 → word addresses 2046,2047,0,1; bram_addr byte values 8184,8188,0,4.
- aresetn asserted while tvalid=1 and tready=0 → all outputs 0 in the same cycle; after release, nothing streams until cfg_force_sync.

Source files
------------

// File: rtl/bram_stream_player.sv
// Pattern BRAM player: streams a programmable word window of a BRAM onto an
// AXI stream in free-run, orbit-synchronous or counted one-shot mode.
// Ports:
//   clk, aresetn              clock, asynchronous active-low reset
//   cfg_*                     decoded configuration, latched on each restart
//   cfg_force_sync            one-cycle restart strobe
//   fc_orbitSync              orbit-sync fast command pulse
//   bram_*                    BRAM read port (registered en/addr, byte addressing)
//   m_axis_*                  output stream (tlast per window pass, tuser after restart)
//   sts_*                     running / one-shot done / completed pass count
module bram_stream_player #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_DEPTH    = 2048,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned PERIOD_W     = 8,
  parameter int unsigned REPEAT_W     = 16
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic                           cfg_enable,
  input  logic [1:0]                     cfg_mode,
  input  logic [$clog2(MEM_DEPTH)-1:0]   cfg_start_addr,
  input  logic [$clog2(MEM_DEPTH):0]     cfg_length,
  input  logic [PERIOD_W-1:0]            cfg_period_orbits,
  input  logic [REPEAT_W-1:0]            cfg_repeat,
  input  logic                           cfg_force_sync,
  input  logic                           fc_orbitSync,
  output logic                           bram_clk,
  output logic                           bram_rst,
  output logic                           bram_en,
  output logic [31:0]                    bram_addr,
  input  logic [DATA_WIDTH-1:0]          bram_dout,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  output logic                           sts_running,
  output logic                           sts_done,
  output logic [15:0]                    sts_pass_count
);

  localparam int unsigned ADDR_W     = $clog2(MEM_DEPTH);
  localparam int unsigned LEN_W      = ADDR_W + 1;
  localparam int unsigned FIFO_DEPTH = READ_LATENCY + 2;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W      = CNT_W + 1;
  localparam int unsigned BYTE_SH    = $clog2(DATA_WIDTH / 8);
  localparam int unsigned RL         = READ_LATENCY;

  localparam logic [1:0] MODE_ORBIT   = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  logic                  en_prev, active, epoch, first_rd;
  logic [1:0]            mode_q;
  logic [ADDR_W-1:0]     start_q;
  logic [LEN_W-1:0]      len_q, offset;
  logic [PERIOD_W-1:0]   period_q, orbit_cnt;
  logic [REPEAT_W-1:0]   repeat_q, passes_issued, passes_done;

  // Read-tag pipeline, one stage per cycle between issue and capture.
  logic [RL:0]           pipe_v, pipe_ep, pipe_last, pipe_user;

  // Shift-register FIFO; entry 0 is the stream head and drives the outputs.
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] nxt_data  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last, fifo_user, nxt_last, nxt_user;
  logic [CNT_W-1:0]      count, wr_idx;
  logic [OCC_W-1:0]      occ_next, inflight;

  logic restart, pop, push, room, oneshot_stop, issue, rd_last, done_set;
  logic [ADDR_W-1:0] word_addr;

  assign bram_clk     = clk;
  assign bram_rst     = ~aresetn;
  assign m_axis_tdata = fifo_data[0];
  assign m_axis_tlast = fifo_last[0];
  assign m_axis_tuser = fifo_user[0];

  // Restart sources and read-issue decision.
  always_comb begin
    restart      = cfg_force_sync | (cfg_enable & ~en_prev) |
                   (cfg_enable & (mode_q == MODE_ORBIT) & fc_orbitSync & (orbit_cnt == '0));
    pop          = m_axis_tvalid & m_axis_tready;
    push         = pipe_v[RL] & (pipe_ep[RL] == epoch);
    wr_idx       = count - CNT_W'(pop);
    occ_next     = OCC_W'(count) + OCC_W'(push) - OCC_W'(pop);
    inflight     = '0;
    for (int k = 0; k < int'(RL); k++) begin
      if (pipe_v[k] && (pipe_ep[k] == epoch)) inflight = inflight + OCC_W'(1);
    end
    // Reserve a slot for every word that will eventually land in the FIFO.
    room         = (occ_next + inflight) < OCC_W'(FIFO_DEPTH);
    oneshot_stop = (mode_q == MODE_ONESHOT) && (passes_issued == repeat_q);
    issue        = active & cfg_enable & ~restart & ~oneshot_stop & room;
    rd_last      = (offset == len_q - LEN_W'(1));
    word_addr    = start_q + offset[ADDR_W-1:0];
    done_set     = pop & m_axis_tlast & (mode_q == MODE_ONESHOT) &
                   ((passes_done + REPEAT_W'(1)) == repeat_q);
  end

  // FIFO next state: pop shifts toward the head, push fills the first free slot.
  always_comb begin
    for (int i = 0; i < int'(FIFO_DEPTH); i++) nxt_data[i] = fifo_data[i];
    nxt_last = fifo_last;
    nxt_user = fifo_user;
    if (pop) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
        nxt_data[i] = fifo_data[i+1];
        nxt_last[i] = fifo_last[i+1];
        nxt_user[i] = fifo_user[i+1];
      end
      nxt_data[FIFO_DEPTH-1] = '0;
      nxt_last[FIFO_DEPTH-1] = 1'b0;
      nxt_user[FIFO_DEPTH-1] = 1'b0;
    end
    if (push) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if (CNT_W'(i) == wr_idx) begin
          nxt_data[i] = bram_dout;
          nxt_last[i] = pipe_last[RL];
          nxt_user[i] = pipe_user[RL];
        end
      end
    end
  end

  // Orbit counter runs independently of playback state.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      orbit_cnt <= '0;
    end else if (cfg_force_sync) begin
      orbit_cnt <= '0;
    end else if (fc_orbitSync) begin
      orbit_cnt <= (orbit_cnt == period_q - PERIOD_W'(1)) ? '0 : orbit_cnt + PERIOD_W'(1);
    end
  end

  // Playback state, read issue, capture and output stage.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      en_prev        <= 1'b1;  // a level-high enable after reset is not an edge
      active         <= 1'b0;
      epoch          <= 1'b0;
      first_rd       <= 1'b0;
      mode_q         <= '0;
      start_q        <= '0;
      len_q          <= LEN_W'(MEM_DEPTH);
      offset         <= '0;
      period_q       <= PERIOD_W'(1);
      repeat_q       <= REPEAT_W'(1);
      passes_issued  <= '0;
      passes_done    <= '0;
      pipe_v         <= '0;
      pipe_ep        <= '0;
      pipe_last      <= '0;
      pipe_user      <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_data[i] <= '0;
      fifo_last      <= '0;
      fifo_user      <= '0;
      count          <= '0;
      m_axis_tvalid  <= 1'b0;
      bram_en        <= 1'b0;
      bram_addr      <= '0;
      sts_running    <= 1'b0;
      sts_done       <= 1'b0;
      sts_pass_count <= '0;
    end else begin
      en_prev <= cfg_enable;
      if (restart) begin
        mode_q         <= cfg_mode;
        start_q        <= cfg_start_addr;
        len_q          <= (cfg_length == '0) ? LEN_W'(MEM_DEPTH) : cfg_length;
        period_q       <= (cfg_period_orbits == '0) ? PERIOD_W'(1) : cfg_period_orbits;
        repeat_q       <= (cfg_repeat == '0) ? REPEAT_W'(1) : cfg_repeat;
        active         <= cfg_enable;
        epoch          <= ~epoch;
        first_rd       <= 1'b1;
        offset         <= '0;
        passes_issued  <= '0;
        passes_done    <= '0;
        pipe_v         <= '0;
        fifo_last      <= '0;
        fifo_user      <= '0;
        count          <= '0;
        m_axis_tvalid  <= 1'b0;
        bram_en        <= 1'b0;
        sts_running    <= cfg_enable;
        sts_done       <= 1'b0;
        sts_pass_count <= '0;
      end else if (!cfg_enable) begin
        active        <= 1'b0;
        pipe_v        <= '0;
        fifo_last     <= '0;
        fifo_user     <= '0;
        count         <= '0;
        m_axis_tvalid <= 1'b0;
        bram_en       <= 1'b0;
        sts_running   <= 1'b0;
      end else begin
        for (int k = 1; k <= int'(RL); k++) begin
          pipe_v[k]    <= pipe_v[k-1];
          pipe_ep[k]   <= pipe_ep[k-1];
          pipe_last[k] <= pipe_last[k-1];
          pipe_user[k] <= pipe_user[k-1];
        end
        pipe_v[0]    <= issue;
        pipe_ep[0]   <= epoch;
        pipe_last[0] <= rd_last;
        pipe_user[0] <= first_rd;
        bram_en      <= issue;
        if (issue) begin
          bram_addr <= 32'(word_addr) << BYTE_SH;
          offset    <= rd_last ? '0 : offset + LEN_W'(1);
          first_rd  <= 1'b0;
          if (rd_last) passes_issued <= passes_issued + REPEAT_W'(1);
        end
        for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_data[i] <= nxt_data[i];
        fifo_last     <= nxt_last;
        fifo_user     <= nxt_user;
        count         <= CNT_W'(occ_next);
        m_axis_tvalid <= (occ_next != '0);
        if (pop && m_axis_tlast) begin
          sts_pass_count <= sts_pass_count + 16'd1;
          passes_done    <= passes_done + REPEAT_W'(1);
        end
        if (done_set) sts_done <= 1'b1;
        sts_running <= active & ~(sts_done | done_set);
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_player.sv
// Directed bench for bram_stream_player: a READ_LATENCY=1 and a READ_LATENCY=2
// instance share all inputs; each has its own BRAM model holding BRAM[i] = i.
module tb_bram_stream_player;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        u;
  } beat_t;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cfg_enable, cfg_force_sync, fc_orbitSync, tready;
  logic [1:0]  cfg_mode;
  logic [10:0] cfg_start_addr;
  logic [11:0] cfg_length;
  logic [7:0]  cfg_period_orbits;
  logic [15:0] cfg_repeat;

  logic        b1_clk, b1_rst, b1_en, t1_valid, t1_last, t1_user, r1, d1;
  logic [31:0] b1_addr, b1_dout, t1_data;
  logic [15:0] pc1;
  logic        b2_clk, b2_rst, b2_en, t2_valid, t2_last, t2_user, r2, d2;
  logic [31:0] b2_addr, b2_dout, b2_stage, t2_data;
  logic [15:0] pc2;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_hs_cyc = -1;
  int done_cyc;
  int n_user;
  logic chk_stab = 1'b0;
  logic s1_prev = 1'b0, s2_prev = 1'b0;
  logic [31:0] h1_data, h2_data;
  beat_t q1[$];
  beat_t q2[$];
  logic [31:0] addr_seen[$];

  always #5 clk = ~clk;

  bram_stream_player #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .aresetn(aresetn), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_start_addr(cfg_start_addr), .cfg_length(cfg_length),
    .cfg_period_orbits(cfg_period_orbits), .cfg_repeat(cfg_repeat),
    .cfg_force_sync(cfg_force_sync), .fc_orbitSync(fc_orbitSync),
    .bram_clk(b1_clk), .bram_rst(b1_rst), .bram_en(b1_en), .bram_addr(b1_addr),
    .bram_dout(b1_dout), .m_axis_tdata(t1_data), .m_axis_tvalid(t1_valid),
    .m_axis_tready(tready), .m_axis_tlast(t1_last), .m_axis_tuser(t1_user),
    .sts_running(r1), .sts_done(d1), .sts_pass_count(pc1));

  bram_stream_player #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .aresetn(aresetn), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_start_addr(cfg_start_addr), .cfg_length(cfg_length),
    .cfg_period_orbits(cfg_period_orbits), .cfg_repeat(cfg_repeat),
    .cfg_force_sync(cfg_force_sync), .fc_orbitSync(fc_orbitSync),
    .bram_clk(b2_clk), .bram_rst(b2_rst), .bram_en(b2_en), .bram_addr(b2_addr),
    .bram_dout(b2_dout), .m_axis_tdata(t2_data), .m_axis_tvalid(t2_valid),
    .m_axis_tready(tready), .m_axis_tlast(t2_last), .m_axis_tuser(t2_user),
    .sts_running(r2), .sts_done(d2), .sts_pass_count(pc2));

  // BRAM models: word i holds value i.
  always @(posedge clk) begin
    if (b1_en) b1_dout <= b1_addr >> 2;
    if (b2_en) b2_stage <= b2_addr >> 2;
    b2_dout <= b2_stage;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Handshake recorder.
  always @(posedge clk) begin
    if (t1_valid && tready) begin
      q1.push_back('{d: t1_data, l: t1_last, u: t1_user});
      if (t1_last) last_hs_cyc = cyc;
    end
    if (t2_valid && tready) q2.push_back('{d: t2_data, l: t2_last, u: t2_user});
    cyc = cyc + 1;
  end

  // Stalled beats must hold their payload until accepted.
  always @(negedge clk) begin
    #1;
    if (chk_stab) begin
      if (s1_prev) begin
        check_eq("hold1_valid", 32'(t1_valid), 32'd1);
        check_eq("hold1_data", t1_data, h1_data);
      end
      if (s2_prev) begin
        check_eq("hold2_valid", 32'(t2_valid), 32'd1);
        check_eq("hold2_data", t2_data, h2_data);
      end
    end
    s1_prev = t1_valid && !tready;
    h1_data = t1_data;
    s2_prev = t2_valid && !tready;
    h2_data = t2_data;
  end

  task automatic verify_beats(input string tag, input int which, input int start, input int len);
    beat_t b;
    int n;
    n = (which == 1) ? q1.size() : q2.size();
    for (int k = 0; k < n; k++) begin
      b = (which == 1) ? q1[k] : q2[k];
      check_eq({tag, "_data"}, b.d, 32'((start + k % len) % 2048));
      check_eq({tag, "_last"}, 32'(b.l), 32'((k % len) == len - 1));
      check_eq({tag, "_user"}, 32'(b.u), 32'(k == 0));
    end
  endtask

  initial begin
    aresetn = 1'b0; cfg_enable = 1'b0; cfg_force_sync = 1'b0; fc_orbitSync = 1'b0;
    tready = 1'b0; cfg_mode = 2'd0; cfg_start_addr = '0; cfg_length = '0;
    cfg_period_orbits = '0; cfg_repeat = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_tvalid", 32'(t1_valid), 32'd0);
    check_eq("rst_tlast", 32'(t1_last), 32'd0);
    check_eq("rst_tuser", 32'(t1_user), 32'd0);
    check_eq("rst_bram_en", 32'(b1_en), 32'd0);
    check_eq("rst_bram_addr", b1_addr, 32'd0);
    check_eq("rst_running", 32'(r1), 32'd0);
    check_eq("rst_done", 32'(d1), 32'd0);
    check_eq("rst_pass", 32'(pc1), 32'd0);
    check_eq("rst_bram_rst", 32'(b1_rst), 32'd1);
    aresetn = 1'b1;
    @(negedge clk);

    // Mode 0 free-run, window 10..13, enable rising edge restarts.
    cfg_start_addr = 11'd10; cfg_length = 12'd4; cfg_mode = 2'd0; tready = 1'b1;
    cfg_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("m0_issue_en", 32'(b1_en), 32'd1);
    check_eq("m0_issue_addr", b1_addr, 32'd40);
    @(negedge clk);
    check_eq("m0_lat_early", 32'(t1_valid), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      check_eq("m0_valid", 32'(t1_valid), 32'd1);
      check_eq("m0_data", t1_data, 32'(10 + k % 4));
      check_eq("m0_last", 32'(t1_last), 32'(k % 4 == 3));
      check_eq("m0_user", 32'(t1_user), 32'(k == 0));
      @(negedge clk);
    end
    check_eq("m0_pass", 32'(pc1), 32'd3);
    check_eq("m0_running", 32'(r1), 32'd1);
    cfg_enable = 1'b0;
    @(negedge clk);
    check_eq("dis_tvalid", 32'(t1_valid), 32'd0);
    check_eq("dis_bram_en", 32'(b1_en), 32'd0);
    check_eq("dis_running", 32'(r1), 32'd0);

    // Random backpressure on both latencies.
    tready = 1'b0; cfg_enable = 1'b1; cfg_force_sync = 1'b1;
    @(negedge clk);
    cfg_force_sync = 1'b0;
    q1.delete(); q2.delete();
    chk_stab = 1'b1;
    repeat (300) begin
      tready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    tready = 1'b0;
    @(negedge clk);
    chk_stab = 1'b0;
    check_eq("bp1_count_ok", 32'(q1.size() >= 60), 32'd1);
    check_eq("bp2_count_ok", 32'(q2.size() >= 60), 32'd1);
    verify_beats("bp1", 1, 10, 4);
    verify_beats("bp2", 2, 10, 4);

    // Mode 1 orbit-sync, period 3.
    cfg_mode = 2'd1; cfg_start_addr = 11'd100; cfg_length = 12'd8; cfg_period_orbits = 8'd3;
    tready = 1'b1; cfg_force_sync = 1'b1;
    @(negedge clk);
    cfg_force_sync = 1'b0;
    repeat (10) @(negedge clk);
    for (int p = 0; p < 7; p++) begin
      fc_orbitSync = 1'b1;
      @(negedge clk);
      fc_orbitSync = 1'b0;
      @(negedge clk);
      check_eq("orb_flush", 32'(t1_valid), 32'(p % 3 != 0));
      @(negedge clk);
      @(negedge clk);
      check_eq("orb_user", 32'(t1_user), 32'(p % 3 == 0));
      if (p % 3 == 0) check_eq("orb_data", t1_data, 32'd100);
      repeat (16) @(negedge clk);
    end
    // Coincident force_sync and orbitSync: one restart, counter left at 0.
    cfg_force_sync = 1'b1; fc_orbitSync = 1'b1;
    @(negedge clk);
    cfg_force_sync = 1'b0; fc_orbitSync = 1'b0;
    n_user = 0;
    repeat (12) begin
      @(negedge clk);
      if (t1_valid && t1_user) n_user++;
    end
    check_eq("coinc_restarts", 32'(n_user), 32'd1);
    fc_orbitSync = 1'b1;
    @(negedge clk);
    fc_orbitSync = 1'b0;
    @(negedge clk);
    check_eq("coinc_cnt0_flush", 32'(t1_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("coinc_cnt0_user", 32'(t1_user), 32'd1);
    check_eq("coinc_cnt0_data", t1_data, 32'd100);

    // Mode 2 one-shot, 2 passes of 3 words.
    cfg_mode = 2'd2; cfg_start_addr = 11'd5; cfg_length = 12'd3; cfg_repeat = 16'd2;
    cfg_force_sync = 1'b1;
    @(negedge clk);
    cfg_force_sync = 1'b0;
    q1.delete(); q2.delete();
    done_cyc = -1;
    repeat (30) begin
      @(negedge clk);
      if (d1 && done_cyc < 0) done_cyc = cyc;
    end
    check_eq("os1_beats", 32'(q1.size()), 32'd6);
    check_eq("os2_beats", 32'(q2.size()), 32'd6);
    verify_beats("os1", 1, 5, 3);
    verify_beats("os2", 2, 5, 3);
    check_eq("os_done_timing", 32'(done_cyc), 32'(last_hs_cyc + 1));
    check_eq("os_pass", 32'(pc1), 32'd2);
    check_eq("os2_pass", 32'(pc2), 32'd2);
    check_eq("os_done", 32'(d1), 32'd1);
    check_eq("os_tvalid", 32'(t1_valid), 32'd0);
    check_eq("os_running", 32'(r1), 32'd0);

    // Address wrap at the top of memory.
    cfg_mode = 2'd0; cfg_start_addr = 11'd2046; cfg_length = 12'd4;
    cfg_force_sync = 1'b1;
    @(negedge clk);
    cfg_force_sync = 1'b0;
    q1.delete(); addr_seen.delete();
    for (int c = 0; c < 20 && addr_seen.size() < 6; c++) begin
      @(negedge clk);
      if (b1_en) addr_seen.push_back(b1_addr);
    end
    check_eq("wrap_addr_count", 32'(addr_seen.size()), 32'd6);
    for (int k = 0; k < addr_seen.size(); k++) begin
      check_eq("wrap_byte_addr", addr_seen[k], 32'((k % 4 < 2) ? (8184 + 4 * (k % 4)) : (4 * (k % 4 - 2))));
    end
    repeat (4) @(negedge clk);
    verify_beats("wrap", 1, 2046, 4);

    // Asynchronous reset while stalled with valid data.
    tready = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("pre_rst_valid", 32'(t1_valid), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("arst_tvalid", 32'(t1_valid), 32'd0);
    check_eq("arst_tvalid2", 32'(t2_valid), 32'd0);
    check_eq("arst_tlast", 32'(t1_last), 32'd0);
    check_eq("arst_tuser", 32'(t1_user), 32'd0);
    check_eq("arst_bram_en", 32'(b1_en), 32'd0);
    check_eq("arst_bram_addr", b1_addr, 32'd0);
    check_eq("arst_running", 32'(r1), 32'd0);
    check_eq("arst_done", 32'(d1), 32'd0);
    @(negedge clk);
    aresetn = 1'b1; tready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_eq("post_rst_idle_valid", 32'(t1_valid), 32'd0);
      check_eq("post_rst_idle_en", 32'(b1_en), 32'd0);
    end
    cfg_force_sync = 1'b1;
    @(negedge clk);
    cfg_force_sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("resume_early", 32'(t1_valid), 32'd0);
    @(negedge clk);
    check_eq("resume_valid", 32'(t1_valid), 32'd1);
    check_eq("resume_data", t1_data, 32'd2046);
    check_eq("resume_user", 32'(t1_user), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
